// File: rtl/chan_sample_mux.sv
`default_nettype none
// ============================================================================
// Module      : chan_sample_mux
// Description : Four-channel sample collector. Per-channel pending registers
//               feed a round-robin arbiter that pushes into a show-ahead FIFO
//               with a channel-tagged valid/ready output and sticky overruns.
//               Optional capture timestamps: define CHAN_MUX_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module chan_sample_mux #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             ch0_data,
    input  logic [DATA_W-1:0]             ch1_data,
    input  logic [DATA_W-1:0]             ch2_data,
    input  logic [DATA_W-1:0]             ch3_data,
    input  logic                          ch0_en,
    input  logic                          ch1_en,
    input  logic                          ch2_en,
    input  logic                          ch3_en,
    output logic [DATA_W-1:0]             out_data,
    output logic [1:0]                    out_ch,
    output logic [15:0]                   out_ts,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [3:0]                    overrun,
    input  logic                          ovr_clr
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
`ifdef CHAN_MUX_TIMESTAMP_EN
    localparam int c_ts_w  = 16;
`else
    localparam int c_ts_w  = 0;
`endif
    localparam int c_entry_w = DATA_W + 2 + c_ts_w;

    logic [3:0]           w_en;
    logic [DATA_W-1:0]    w_din [4];
    logic [DATA_W-1:0]    r_pend_data [4];
    logic [3:0]           r_pend_v;
    logic [1:0]           r_rr_ptr;
    logic [3:0]           r_overrun;
    logic [3:0]           w_ovr_set;

    logic                 w_grant_vld;
    logic [1:0]           w_grant_idx;
    logic [3:0]           w_grant_oh;

    logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_entry_w-1:0] w_wdata;
    logic [c_entry_w-1:0] w_head;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_lvl_w-1:0]   r_level;
    logic [c_lvl_w-1:0]   w_level_nxt;
    logic                 r_full;
    logic                 r_valid;
    logic                 w_push;
    logic                 w_pop;

    assign w_en     = {ch3_en, ch2_en, ch1_en, ch0_en};
    assign w_din[0] = ch0_data;
    assign w_din[1] = ch1_data;
    assign w_din[2] = ch2_data;
    assign w_din[3] = ch3_data;

`ifdef CHAN_MUX_TIMESTAMP_EN
    logic [15:0] r_ts_cnt;
    logic [15:0] r_pend_ts [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts_cnt <= '0;
            for (int n = 0; n < 4; n++) begin
                r_pend_ts[n] <= '0;
            end
        end else begin
            r_ts_cnt <= r_ts_cnt + 16'd1;
            for (int n = 0; n < 4; n++) begin
                if (w_en[n]) begin
                    r_pend_ts[n] <= r_ts_cnt;
                end
            end
        end
    end

    assign w_wdata = {r_pend_data[w_grant_idx], w_grant_idx, r_pend_ts[w_grant_idx]};
    assign out_ts  = w_head[15:0];
`else
    assign w_wdata = {r_pend_data[w_grant_idx], w_grant_idx};
    assign out_ts  = '0;
`endif

    // Walk from the highest offset down so the closest set channel to rr_ptr wins.
    always_comb begin
        logic [1:0] v_idx;
        w_grant_vld = 1'b0;
        w_grant_idx = r_rr_ptr;
        v_idx       = r_rr_ptr;
        if (!r_full) begin
            for (int i = 3; i >= 0; i--) begin
                v_idx = r_rr_ptr + 2'(i);
                if (r_pend_v[v_idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = v_idx;
                end
            end
        end
    end

    assign w_grant_oh = w_grant_vld ? (4'b0001 << w_grant_idx) : 4'b0000;
    assign w_ovr_set  = w_en & r_pend_v & ~w_grant_oh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_v  <= '0;
            r_rr_ptr  <= '0;
            r_overrun <= '0;
            for (int n = 0; n < 4; n++) begin
                r_pend_data[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_en[n]) begin
                    r_pend_data[n] <= w_din[n];
                    r_pend_v[n]    <= 1'b1;
                end else if (w_grant_oh[n]) begin
                    r_pend_v[n]    <= 1'b0;
                end
            end
            if (w_grant_vld) begin
                r_rr_ptr <= w_grant_idx + 2'd1;
            end
            r_overrun <= (ovr_clr ? 4'b0000 : r_overrun) | w_ovr_set;
        end
    end

    assign w_push = w_grant_vld;
    assign w_pop  = r_valid && out_ready;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_lvl_w'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - c_lvl_w'(1);
        end
    end

    // Storage is cleared on reset so the show-ahead outputs read 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wdata;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_lvl_w'(FIFO_DEPTH));
            r_valid <= (w_level_nxt != '0);
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign out_data   = w_head[c_entry_w-1 -: DATA_W];
    assign out_ch     = w_head[c_ts_w +: 2];
    assign out_valid  = r_valid;
    assign fifo_level = r_level;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_chan_sample_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_chan_sample_mux
// Description : Directed vector table plus hand sequences for chan_sample_mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chan_sample_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ch0_data, ch1_data, ch2_data, ch3_data;
    logic        ch0_en, ch1_en, ch2_en, ch3_en;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic [15:0] out_ts;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic [3:0]  overrun;
    logic        ovr_clr;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_ts;

    chan_sample_mux #(.DATA_W(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .ch0_data(ch0_data), .ch1_data(ch1_data), .ch2_data(ch2_data), .ch3_data(ch3_data),
        .ch0_en(ch0_en), .ch1_en(ch1_en), .ch2_en(ch2_en), .ch3_en(ch3_en),
        .out_data(out_data), .out_ch(out_ch), .out_ts(out_ts), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    // Reference timestamp counter: the value a strobe driven now will capture.
    always @(posedge clk) m_ts <= rst ? 16'd0 : m_ts + 16'd1;

    typedef struct {
        logic [3:0]  en;
        logic [15:0] d0, d1, d2, d3;
        logic        v;
        logic [15:0] data;
        logic [1:0]  ch;
        logic [3:0]  lvl;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic [3:0] en, input logic [15:0] d0, d1, d2, d3,
                                input logic v, input logic [15:0] data, input logic [1:0] ch,
                                input logic [3:0] lvl);
        vec_t r;
        r.en = en; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.d3 = d3;
        r.v = v; r.data = data; r.ch = ch; r.lvl = lvl;
        return r;
    endfunction

    function automatic logic [15:0] ts_exp(input logic [15:0] t);
`ifdef CHAN_MUX_TIMESTAMP_EN
        return t;
`else
        return 16'h0000 & t;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input logic [15:0] d0, d1, d2, d3);
        {ch3_en, ch2_en, ch1_en, ch0_en} = en;
        ch0_data = d0; ch1_data = d1; ch2_data = d2; ch3_data = d3;
    endtask

    task automatic do_reset();
        rst = 1'b1; ovr_clr = 1'b0; out_ready = 1'b0;
        drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic check_out(input string name, input logic v, input logic [15:0] data,
                             input logic [1:0] ch, input logic [15:0] ts,
                             input logic [3:0] lvl, input logic [3:0] ovr);
        chk({name, ".valid"}, out_valid, v);
        chk({name, ".level"}, fifo_level, lvl);
        chk({name, ".ovr"}, overrun, ovr);
        if (v) begin
            chk({name, ".data"}, out_data, data);
            chk({name, ".ch"}, out_ch, ch);
            chk({name, ".ts"}, out_ts, ts);
        end
    endtask

    initial begin : main
        logic [15:0] exp_d [10];
        logic [1:0]  exp_c [10];
        logic [15:0] cap;
        int          guard;

        vecs[0]  = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b0, 16'h0,    2'd0, 4'd0);
        vecs[1]  = mk(4'hF, 16'hA0, 16'hA1, 16'hA2,   16'hA3, 1'b0, 16'h0,    2'd0, 4'd0);
        vecs[2]  = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b1, 16'hA0,   2'd0, 4'd1);
        vecs[3]  = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b1, 16'hA1,   2'd1, 4'd1);
        vecs[4]  = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b1, 16'hA2,   2'd2, 4'd1);
        vecs[5]  = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b1, 16'hA3,   2'd3, 4'd1);
        vecs[6]  = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b0, 16'h0,    2'd0, 4'd0);
        vecs[7]  = mk(4'hF, 16'hB0, 16'hB1, 16'hB2,   16'hB3, 1'b0, 16'h0,    2'd0, 4'd0);
        vecs[8]  = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b1, 16'hB0,   2'd0, 4'd1);
        vecs[9]  = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b1, 16'hB1,   2'd1, 4'd1);
        vecs[10] = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b1, 16'hB2,   2'd2, 4'd1);
        vecs[11] = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b1, 16'hB3,   2'd3, 4'd1);
        vecs[12] = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b0, 16'h0,    2'd0, 4'd0);
        vecs[13] = mk(4'h4, 16'h0,  16'h0,  16'h1234, 16'h0,  1'b0, 16'h0,    2'd0, 4'd0);
        vecs[14] = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b1, 16'h1234, 2'd2, 4'd1);
        vecs[15] = mk(4'h0, 16'h0,  16'h0,  16'h0,    16'h0,  1'b0, 16'h0,    2'd0, 4'd0);

        // Reset state
        do_reset();
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.data", out_data, 16'h0);
        chk("rst.ch", out_ch, 2'd0);
        chk("rst.ts", out_ts, 16'h0);
        chk("rst.level", fifo_level, 4'd0);
        chk("rst.ovr", overrun, 4'd0);

        // Round-robin and single-sample table
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].en, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
            tick();
            chk($sformatf("vec%0d.valid", i), out_valid, vecs[i].v);
            chk($sformatf("vec%0d.level", i), fifo_level, vecs[i].lvl);
            chk($sformatf("vec%0d.ovr", i), overrun, 4'd0);
            if (vecs[i].v) begin
                chk($sformatf("vec%0d.data", i), out_data, vecs[i].data);
                chk($sformatf("vec%0d.ch", i), out_ch, vecs[i].ch);
            end
        end
        drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Single sample at timestamp 10, two-cycle latency
        do_reset();
        out_ready = 1'b1;
        guard = 0;
        while (m_ts != 16'd10 && guard < 100) begin tick(); guard++; end
        chk("single.reach_ts", m_ts, 16'd10);
        drive(4'h4, 16'h0, 16'h0, 16'h1234, 16'h0);
        tick();
        drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        check_out("single.e0", 1'b0, 16'h0, 2'd0, 16'h0, 4'd0, 4'd0);
        tick();
        check_out("single.e1", 1'b1, 16'h1234, 2'd2, ts_exp(16'd10), 4'd1, 4'd0);
        tick();
        check_out("single.e2", 1'b0, 16'h0, 2'd0, 16'h0, 4'd0, 4'd0);

        // Backpressure: ch1 strobed 10 times into a stalled FIFO
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            drive(4'h2, 16'h0, 16'(k), 16'h0, 16'h0);
            tick();
        end
        drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        chk("bp.level", fifo_level, 4'd8);
        chk("bp.ovr", overrun, 4'b0010);
        chk("bp.head", out_data, 16'd1);
        chk("bp.valid", out_valid, 1'b1);

        // Overrun clear racing a new ch3 overrun, then a plain clear
        drive(4'h8, 16'h0, 16'h0, 16'h0, 16'h0031);
        tick();
        chk("race.pre_ovr", overrun, 4'b0010);
        drive(4'h8, 16'h0, 16'h0, 16'h0, 16'h0033);
        ovr_clr = 1'b1;
        tick();
        drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        ovr_clr = 1'b0;
        chk("race.ovr", overrun, 4'b1000);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("clr.ovr", overrun, 4'b0000);
        chk("clr.level", fifo_level, 4'd8);

        // Drain: 1..8, then ch3 (rr_ptr=2 after ch1), then the surviving 10
        for (int k = 0; k < 8; k++) begin exp_d[k] = 16'(k + 1); exp_c[k] = 2'd1; end
        exp_d[8] = 16'h0033; exp_c[8] = 2'd3;
        exp_d[9] = 16'd10;   exp_c[9] = 2'd1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("drain%0d.valid", k), out_valid, 1'b1);
            chk($sformatf("drain%0d.data", k), out_data, exp_d[k]);
            chk($sformatf("drain%0d.ch", k), out_ch, exp_c[k]);
            tick();
        end
        chk("drain.end_valid", out_valid, 1'b0);
        chk("drain.end_level", fifo_level, 4'd0);

        // Reset mid-operation with level 5 and ch0 pending
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(4'h1, 16'h51 + 16'(k), 16'h0, 16'h0, 16'h0);
            tick();
        end
        drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("mid.level5", fifo_level, 4'd5);
        chk("mid.head", out_data, 16'h51);
        rst = 1'b1;
        drive(4'h2, 16'h0, 16'hEE, 16'h0, 16'h0);
        tick();
        rst = 1'b0;
        drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        check_out("mid.rst", 1'b0, 16'h0, 2'd0, 16'h0, 4'd0, 4'd0);
        tick();
        check_out("mid.idle1", 1'b0, 16'h0, 2'd0, 16'h0, 4'd0, 4'd0);
        tick();
        check_out("mid.idle2", 1'b0, 16'h0, 2'd0, 16'h0, 4'd0, 4'd0);
        out_ready = 1'b1;
        cap = m_ts;
        drive(4'h1, 16'h77, 16'h0, 16'h0, 16'h0);
        tick();
        drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        check_out("mid.s0", 1'b0, 16'h0, 2'd0, 16'h0, 4'd0, 4'd0);
        tick();
        check_out("mid.s1", 1'b1, 16'h77, 2'd0, ts_exp(cap), 4'd1, 4'd0);

`ifdef CHAN_MUX_TIMESTAMP_EN
        // Timestamp wrap across 0xFFFF -> 0x0000
        do_reset();
        out_ready = 1'b1;
        guard = 0;
        while (m_ts != 16'hFFFF && guard < 70000) begin tick(); guard++; end
        chk("wrap.reach_ts", m_ts, 16'hFFFF);
        drive(4'h1, 16'hAAAA, 16'h0, 16'h0, 16'h0);
        tick();
        drive(4'h1, 16'hBBBB, 16'h0, 16'h0, 16'h0);
        tick();
        drive(4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        check_out("wrap.first", 1'b1, 16'hAAAA, 2'd0, 16'hFFFF, 4'd1, 4'd0);
        tick();
        check_out("wrap.second", 1'b1, 16'hBBBB, 2'd0, 16'h0000, 4'd1, 4'd0);
        tick();
        check_out("wrap.empty", 1'b0, 16'h0, 2'd0, 16'h0, 4'd0, 4'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
